// File: rtl/ram_stream_reader_pkg.sv
// Shared types and constants for the RAM stream reader: sequencer states and
// output buffer sizing.
package ram_stream_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam int BUF_DEPTH = 2;
    localparam int BUF_CNT_W = $clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/ram_stream_reader_skid_fifo.sv
// Two-entry shift-style FIFO; entry 0 is always the head, so the head output
// comes straight from a register.
module stream_skid_fifo
    import ram_stream_reader_pkg::*;
#(
    parameter int WIDTH = 33
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push_i,
    input  logic [WIDTH-1:0]     din_i,
    input  logic                 pop_i,
    output logic [WIDTH-1:0]     head_o,
    output logic                 valid_o,
    output logic [BUF_CNT_W-1:0] count_o
);

    logic [WIDTH-1:0]     entry0_q, entry0_d;
    logic [WIDTH-1:0]     entry1_q, entry1_d;
    logic [BUF_CNT_W-1:0] count_q, count_d;
    logic                 doPush;
    logic                 doPop;

    always_comb begin
        entry0_d = entry0_q;
        entry1_d = entry1_q;
        count_d  = count_q;
        doPop    = pop_i && (count_q != '0);
        doPush   = push_i && ((count_q < BUF_CNT_W'(BUF_DEPTH)) || doPop);

        case ({doPush, doPop})
            2'b10: begin
                if (count_q == '0) begin
                    entry0_d = din_i;
                end else begin
                    entry1_d = din_i;
                end
                count_d = count_q + BUF_CNT_W'(1);
            end
            2'b01: begin
                entry0_d = entry1_q;
                count_d  = count_q - BUF_CNT_W'(1);
            end
            2'b11: begin
                // Simultaneous push and pop keeps the count; shift when two deep.
                if (count_q == BUF_CNT_W'(1)) begin
                    entry0_d = din_i;
                end else begin
                    entry0_d = entry1_q;
                    entry1_d = din_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry0_q <= '0;
            entry1_q <= '0;
            count_q  <= '0;
        end else begin
            entry0_q <= entry0_d;
            entry1_q <= entry1_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = entry0_q;
    assign valid_o = (count_q != '0);
    assign count_o = count_q;

endmodule

// File: rtl/ram_stream_reader.sv
// Walks a contiguous range of a 1-cycle-latency RAM read port and delivers the
// words as a valid/ready stream with a last flag, throttled by buffer credit.
module ram_stream_reader
    import ram_stream_reader_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
);

    localparam int LEN_W = ADDR_WIDTH + 1;
    localparam int OCC_W = BUF_CNT_W + 1;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] rdAddr_q, rdAddr_d;
    logic [LEN_W-1:0]      length_q, length_d;
    logic [LEN_W-1:0]      issued_q, issued_d;
    logic                  inflight_q, inflight_d;
    logic                  inflightLast_q, inflightLast_d;
    logic                  done_q, done_d;

    logic                  issue;
    logic                  pop;
    logic                  issueIsLast;
    logic [OCC_W-1:0]      occupancy;
    logic [BUF_CNT_W-1:0]  fifoCount;
    logic [DATA_WIDTH:0]   fifoHead;
    logic                  fifoValid;

    assign pop         = fifoValid & m_ready;
    assign issueIsLast = ((issued_q + LEN_W'(1)) == length_q);
    // Words already buffered or on their way, after this cycle's pop leaves.
    assign occupancy   = OCC_W'(fifoCount) + OCC_W'(inflight_q) - OCC_W'(pop);

    always_comb begin
        state_d        = state_q;
        rdAddr_d       = rdAddr_q;
        length_d       = length_q;
        issued_d       = issued_q;
        done_d         = 1'b0;
        issue          = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    rdAddr_d = base_addr;
                    length_d = length;
                    issued_d = '0;
                    state_d  = (length == '0) ? DRAIN : READ;
                end
            end
            READ: begin
                if (occupancy < OCC_W'(BUF_DEPTH)) begin
                    issue    = 1'b1;
                    rdAddr_d = rdAddr_q + ADDR_WIDTH'(1);
                    issued_d = issued_q + LEN_W'(1);
                    if (issueIsLast) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!inflight_q && (occupancy == '0)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        inflight_d     = issue;
        inflightLast_d = issue & issueIsLast;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            rdAddr_q       <= '0;
            length_q       <= '0;
            issued_q       <= '0;
            inflight_q     <= 1'b0;
            inflightLast_q <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            rdAddr_q       <= rdAddr_d;
            length_q       <= length_d;
            issued_q       <= issued_d;
            inflight_q     <= inflight_d;
            inflightLast_q <= inflightLast_d;
            done_q         <= done_d;
        end
    end

    stream_skid_fifo #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (inflight_q),
        .din_i   ({inflightLast_q, rd_data}),
        .pop_i   (pop),
        .head_o  (fifoHead),
        .valid_o (fifoValid),
        .count_o (fifoCount)
    );

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign rd_addr = rdAddr_q;
    assign m_valid = fifoValid;
    assign m_data  = fifoHead[DATA_WIDTH-1:0];
    assign m_last  = fifoValid & fifoHead[DATA_WIDTH];

endmodule

// File: tb/tb_ram_stream_reader.sv
// Scoreboard bench for ram_stream_reader: a behavioural RAM holding ram[i]=i
// feeds the reader; a monitor checks every accepted beat against a queue.
module tb_ram_stream_reader;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [9:0]  base_addr;
   logic [10:0] length;
   logic        busy;
   logic        done;
   logic [9:0]  rd_addr;
   logic [31:0] rd_data;
   logic        m_valid;
   logic        m_ready;
   logic [31:0] m_data;
   logic        m_last;

   int checks = 0;
   int errors = 0;

   logic [32:0] expQ[$];
   logic [31:0] ram[1024];

   bit          patternMode = 0;
   bit          readyConst  = 1;

   ram_stream_reader #(
      .ADDR_WIDTH (10),
      .DATA_WIDTH (32)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .base_addr (base_addr),
      .length    (length),
      .busy      (busy),
      .done      (done),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .m_last    (m_last)
   );

   // Clock generation, 10 ns period
   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   // Read target: synchronous RAM with one cycle of read latency
   initial begin
      for (int i = 0; i < 1024; i++) ram[i] = i;
   end

   always @(posedge clk) rd_data <= ram[rd_addr];

   // Consumer ready: constant or a fixed rotating on/off pattern
   initial begin
      logic [31:0] pat;
      int          idx;
      pat = 32'b1011_0010_0111_0001_1100_1010_0110_1001;
      idx = 0;
      m_ready = 1;
      forever begin
         @(posedge clk);
         #2;
         if (patternMode) begin
            m_ready = pat[idx];
            idx = (idx + 1) % 32;
         end else begin
            m_ready = readyConst;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   // Queue the expected words and pulse start for one sampling edge
   task automatic applyStimulus(input logic [9:0] b, input logic [10:0] n);
      for (int i = 0; i < int'(n); i++)
         expQ.push_back({(i == int'(n) - 1), 32'((int'(b) + i) % 1024)});
      start     = 1;
      base_addr = b;
      length    = n;
      @(posedge clk);
      #1;
      start = 0;
   endtask

   // Walk cycles from k0 until done, checking timing landmarks along the way
   task automatic waitDone(input string name, input int k0, input int expDone,
                           input int expFirst, input logic [9:0] expAddr1, input int budget);
      bit seen;
      int doneAt;
      int firstV;
      seen   = 0;
      doneAt = -1;
      firstV = -1;
      for (int k = k0; k < k0 + budget; k++) begin
         @(negedge clk);
         if (k == 1) begin
            checkOutput({name, "_busy_c1"}, busy, 1);
            checkOutput({name, "_rdaddr_c1"}, rd_addr, expAddr1);
         end
         if (m_valid && firstV < 0) firstV = k;
         if (done) begin
            seen   = 1;
            doneAt = k;
            break;
         end
      end
      checkOutput({name, "_done_seen"}, seen, 1);
      if (expDone >= 0) checkOutput({name, "_done_cycle"}, doneAt, expDone);
      checkOutput({name, "_busy_at_done"}, busy, 0);
      checkOutput({name, "_first_valid"}, firstV, expFirst);
      checkOutput({name, "_queue_empty"}, expQ.size(), 0);
   endtask

   task automatic checkReset(input string name);
      checkOutput({name, "_busy"}, busy, 0);
      checkOutput({name, "_done"}, done, 0);
      checkOutput({name, "_m_valid"}, m_valid, 0);
      checkOutput({name, "_m_last"}, m_last, 0);
      checkOutput({name, "_m_data"}, m_data, 0);
      checkOutput({name, "_rd_addr"}, rd_addr, 0);
   endtask

   // Monitor: compares accepted beats with the scoreboard and checks stall stability
   initial begin
      bit          prevStall;
      logic [31:0] prevData;
      logic        prevLast;
      logic [32:0] exp;
      prevStall = 0;
      prevData  = 0;
      prevLast  = 0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prevStall = 0;
         end else begin
            if (prevStall) begin
               checkOutput("stall_valid", m_valid, 1);
               checkOutput("stall_data", m_data, prevData);
               checkOutput("stall_last", m_last, prevLast);
            end
            if (m_valid && m_ready) begin
               checkOutput("beat_expected", expQ.size() > 0, 1);
               if (expQ.size() > 0) begin
                  exp = expQ.pop_front();
                  checkOutput("beat", {m_last, m_data}, exp);
               end
            end
            prevStall = m_valid && !m_ready;
            prevData  = m_data;
            prevLast  = m_last;
         end
      end
   end

   // Watchdog
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] simulation time limit");
   end

   // Directed stimulus sequence
   initial begin
      rst_n     = 0;
      start     = 0;
      base_addr = 0;
      length    = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkReset("reset");
      @(posedge clk);
      #1;
      rst_n = 1;

      $display("[TB] basic transfer base=5 length=4");
      applyStimulus(10'd5, 11'd4);
      waitDone("basic", 1, 7, 3, 10'd5, 50);

      $display("[TB] back-to-back wrap transfer base=1022 length=4");
      applyStimulus(10'd1022, 11'd4);
      waitDone("wrap", 1, 7, 3, 10'd1022, 50);

      $display("[TB] backpressure transfer length=16");
      patternMode = 1;
      applyStimulus(10'd0, 11'd16);
      waitDone("stall", 1, -1, 3, 10'd0, 200);
      patternMode = 0;
      readyConst  = 1;
      @(posedge clk);
      #3;

      $display("[TB] zero-length transfer");
      applyStimulus(10'd7, 11'd0);
      waitDone("zero", 1, 2, -1, 10'd7, 20);

      $display("[TB] start while busy is ignored");
      @(posedge clk);
      #1;
      applyStimulus(10'd10, 11'd3);
      checkOutput("ignore_busy_c1", busy, 1);
      start     = 1;
      base_addr = 10'd200;
      length    = 11'd5;
      @(posedge clk);
      #1;
      start = 0;
      waitDone("ignore", 2, 6, 3, 10'd10, 50);
      repeat (3) begin
         @(negedge clk);
         checkOutput("ignore_idle_valid", m_valid, 0);
      end

      $display("[TB] full-range transfer length=1024");
      @(posedge clk);
      #1;
      applyStimulus(10'd0, 11'd1024);
      waitDone("full", 1, 1027, 3, 10'd0, 1100);
      @(negedge clk);
      checkOutput("full_done_once", done, 0);

      $display("[TB] reset mid-transfer under backpressure");
      readyConst = 0;
      applyStimulus(10'd50, 11'd8);
      repeat (5) @(posedge clk);
      #1;
      rst_n = 0;
      #1;
      checkReset("midreset");
      expQ.delete();
      @(posedge clk);
      #1;
      rst_n      = 1;
      readyConst = 1;
      applyStimulus(10'd300, 11'd3);
      waitDone("restart", 1, 6, 3, 10'd300, 50);

      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
